// File: rtl/lii_router_pkg.sv
// ---------------------------------------------------------------------------
// lii_router_pkg
// Shared definitions for LII router output ports.
//   state_t : output-port lock state (IDLE = free for arbitration,
//             LOCKED = a packet owns the link until its tail flit)
//   ptr_w   : width of an input index for N inputs (at least 1 bit)
//   cred_w  : width of a credit counter able to hold 0..DEPTH
// ---------------------------------------------------------------------------
package lii_router_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int ptr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cred_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/lii_rr_pick.sv
// ---------------------------------------------------------------------------
// lii_rr_pick
// Combinational rotating-priority picker. Scans req starting at ptr, wrapping
// through N-1 back to 0, and returns the first requester.
// Ports:
//   req   in  N   request vector
//   ptr   in  PW  index with highest priority this cycle
//   gnt   out N   one-hot grant (all zero when nothing requests)
//   idx   out PW  index of the granted requester (0 when none)
//   found out 1   at least one request was present
// ---------------------------------------------------------------------------
module lii_rr_pick
    import lii_router_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          found
);

    always_comb begin
        int j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/lii_wormhole_scheduler.sv
// ---------------------------------------------------------------------------
// lii_wormhole_scheduler
// Shares one output link between N input FIFOs with wormhole switching.
// A round-robin pick chooses a packet head; that input then owns the link
// until its tail flit is transferred. Every transfer consumes one downstream
// credit; credit_ret gives one back.
//
// Handshake: in_valid[i] means input i has a flit at its FIFO head and must
// not depend on in_ready. in_ready[i] is a one-hot pop: the flit moves in the
// same cycle it is asserted. out_valid equals |in_ready and is never high
// while credits is 0. The downstream side cannot back-pressure other than by
// withholding credits.
//
// Optional feature (macro LII_SCHED_WATCHDOG_EN): a watchdog releases a lock
// whose owner has shown no valid flit for TIMEOUT consecutive cycles, and
// pulses wd_fire for one cycle. Without the macro wd_fire is tied low.
//
// Ports:
//   clk        in  1   rising-edge clock
//   rst        in  1   synchronous reset, active-high
//   in_valid   in  N   input i has a flit
//   in_tail    in  N   head flit of input i is a packet tail
//   in_ready   out N   one-hot pop to input i
//   out_valid  out 1   flit driven on the output link this cycle
//   out_sel    out PW  index of the transferring input
//   out_tail   out 1   transferred flit is a tail
//   credit_ret in  1   downstream freed one slot
//   credits    out CW  current credit count
//   locked     out 1   a packet owns the output
//   wd_fire    out 1   one-cycle pulse: watchdog released a lock
//   dbg_state  out 1   FSM state for observation
//   dbg_ptr    out PW  round-robin pointer for observation
// ---------------------------------------------------------------------------
module lii_wormhole_scheduler
    import lii_router_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int DEPTH   = 4,
    parameter  int TIMEOUT = 64,
    localparam int PW      = ptr_w(N),
    localparam int CW      = cred_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_valid,
    input  logic [N-1:0]  in_tail,
    output logic [N-1:0]  in_ready,
    output logic          out_valid,
    output logic [PW-1:0] out_sel,
    output logic          out_tail,
    input  logic          credit_ret,
    output logic [CW-1:0] credits,
    output logic          locked,
    output logic          wd_fire,
    output state_t        dbg_state,
    output logic [PW-1:0] dbg_ptr
);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [CW-1:0] credits_q;

    logic [N-1:0]  pick_gnt;
    logic [PW-1:0] pick_idx;
    logic          pick_found;
    logic          xfer;

    // Index after i, wrapping at N-1 (constant 0 when N == 1).
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        if (int'(i) >= N - 1) return '0;
        else                  return i + 1'b1;
    endfunction

    lii_rr_pick #(.N(N)) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Zero-latency grant: decided from current state and inputs.
    always_comb begin
        in_ready = '0;
        out_sel  = '0;
        if (credits_q != '0) begin
            if (state == IDLE) begin
                if (pick_found) begin
                    in_ready = pick_gnt;
                    out_sel  = pick_idx;
                end
            end else if (in_valid[owner]) begin
                in_ready[owner] = 1'b1;
                out_sel         = owner;
            end
        end
    end

    assign xfer      = |in_ready;
    assign out_valid = xfer;
    assign out_tail  = xfer && in_tail[out_sel];
    assign credits   = credits_q;
    assign locked    = (state == LOCKED);
    assign dbg_state = state;
    assign dbg_ptr   = ptr;

`ifdef LII_SCHED_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign wd_fire        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            credits_q <= CW'(DEPTH);
`ifdef LII_SCHED_WATCHDOG_EN
            wd_cnt    <= '0;
            wd_fire   <= 1'b0;
`endif
        end else begin
`ifdef LII_SCHED_WATCHDOG_EN
            wd_fire <= 1'b0;
`endif
            // Simultaneous consume and return cancel out; returns saturate at DEPTH.
            if (xfer && !credit_ret) begin
                credits_q <= credits_q - 1'b1;
            end else if (credit_ret && !xfer && credits_q != CW'(DEPTH)) begin
                credits_q <= credits_q + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (out_tail) begin
                            ptr <= next_idx(out_sel);
                        end else begin
                            state <= LOCKED;
                            owner <= out_sel;
`ifdef LII_SCHED_WATCHDOG_EN
                            wd_cnt <= '0;
`endif
                        end
                    end
                end
                LOCKED: begin
                    if (xfer && out_tail) begin
                        state <= IDLE;
                        ptr   <= next_idx(owner);
                    end
`ifdef LII_SCHED_WATCHDOG_EN
                    // Only an absent owner flit counts; a credit stall with the
                    // owner valid is legitimate back-pressure and clears the count.
                    else if (!in_valid[owner]) begin
                        if (wd_cnt == WW'(TIMEOUT - 1)) begin
                            state   <= IDLE;
                            ptr     <= next_idx(owner);
                            wd_fire <= 1'b1;
                            wd_cnt  <= '0;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end else begin
                        wd_cnt <= '0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A return with the buffer already fully credited means downstream
    // accounting has drifted; the counter saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            credit_overflow: assert (!(credit_ret && !xfer && credits_q == CW'(DEPTH)))
                else $warning("credit_ret received with credits already at DEPTH");
        end
    end
`endif

endmodule
